// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing fetch/decode/execute/memory/writeback for a multicycle RISC-V datapath
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        reg_write,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
        MEMORY = 3'd4, WRITEBACK = 3'd5, TRAP = 3'd7
    } state_t;
    typedef enum logic [2:0] {
        C_NONE, C_R, C_LOAD, C_STORE, C_IMM, C_BR, C_JAL, C_JALR
    } cls_t;
    state_t st, nxt;
    cls_t   cls, dcls;
    logic   retire;
    // classify the opcode presented during DECODE
    always_comb begin
        dcls = opcode == 7'b0110011 ? C_R :
               opcode == 7'b0000011 ? C_LOAD :
               opcode == 7'b0100011 ? C_STORE :
               opcode == 7'b0010011 ? C_IMM :
               opcode == 7'b1100011 ? C_BR :
               opcode == 7'b1101111 ? C_JAL :
               opcode == 7'b1100111 ? C_JALR : C_NONE;
    end
    // next-state selection; TRAP and the unused encoding stay trapped until reset
    always_comb begin
        nxt = st;
        case (st)
            IDLE:      nxt = FETCH;
            FETCH:     nxt = mem_ready ? DECODE : FETCH;
            DECODE:    nxt = dcls == C_NONE ? TRAP : EXECUTE;
            EXECUTE:   nxt = (cls == C_LOAD || cls == C_STORE) ? MEMORY :
                             cls == C_BR ? FETCH : WRITEBACK;
            MEMORY:    nxt = !mem_ready ? MEMORY : cls == C_LOAD ? WRITEBACK : FETCH;
            WRITEBACK: nxt = FETCH;
            default:   nxt = TRAP;
        endcase
    end
    assign retire = nxt == FETCH && (st == EXECUTE || st == MEMORY || st == WRITEBACK);
    // state, latched instruction class and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st      <= IDLE;
            cls     <= C_NONE;
            instret <= 32'd0;
        end else begin
            st <= nxt;
            if (st == DECODE) cls <= dcls;
            if (retire) instret <= instret + 32'd1;
        end
    end
    assign state         = st;
    assign illegal       = st == TRAP;
    assign mem_req       = st == FETCH || st == MEMORY;
    assign mem_we        = st == MEMORY && cls == C_STORE;
    assign ir_write      = st == FETCH && mem_ready;
    assign pc_write      = (st == FETCH && mem_ready) ||
                           (st == EXECUTE && (cls == C_JAL || cls == C_JALR));
    assign pc_write_cond = st == EXECUTE && cls == C_BR && zero;
    assign reg_write     = st == WRITEBACK;
    assign mem_to_reg    = st == WRITEBACK && cls == C_LOAD;
    assign alu_src       = st == EXECUTE && (cls == C_IMM || cls == C_LOAD ||
                                             cls == C_STORE || cls == C_JALR);
    assign alu_op        = st != EXECUTE ? 2'b00 :
                           cls == C_R ? 2'b10 :
                           cls == C_IMM ? 2'b11 :
                           cls == C_BR ? 2'b01 : 2'b00;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed-vector check of the multicycle controller
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'b0110011;
    logic        mem_ready = 1'b1;
    logic        zero = 1'b0;
    logic        mem_req, mem_we, ir_write, pc_write, pc_write_cond;
    logic        reg_write, alu_src, mem_to_reg, illegal;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instret;
    int errors = 0;
    int checks = 0;

    localparam logic [6:0] OP_R = 7'b0110011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                           OP_IMM = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .reg_write(reg_write), .alu_src(alu_src),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .state(state), .illegal(illegal),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_state", 32'(state), 0);
        check("rst_memreq", 32'(mem_req), 0);
        check("rst_instret", instret, 0);
        step();
        reset = 1'b0;
        step();
        check("r_fetch", 32'(state), 1);
        check("r_irwrite", 32'(ir_write), 1);
        check("r_pcwrite", 32'(pc_write), 1);
        step();
        check("r_decode", 32'(state), 2);
        check("r_dec_rw", 32'(reg_write), 0);
        step();
        check("r_exec", 32'(state), 3);
        check("r_aluop", 32'(alu_op), 2);
        check("r_alusrc", 32'(alu_src), 0);
        check("r_ex_rw", 32'(reg_write), 0);
        step();
        check("r_wb", 32'(state), 5);
        check("r_wb_rw", 32'(reg_write), 1);
        check("r_wb_m2r", 32'(mem_to_reg), 0);
        step();
        check("r_fetch2", 32'(state), 1);
        check("r_instret", instret, 1);
        check("r_f_rw", 32'(reg_write), 0);
        opcode = OP_LOAD;
        step();
        step();
        check("ld_exec", 32'(state), 3);
        check("ld_alusrc", 32'(alu_src), 1);
        check("ld_aluop", 32'(alu_op), 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld_mem_state", 32'(state), 4);
            check("ld_memreq", 32'(mem_req), 1);
            check("ld_memwe", 32'(mem_we), 0);
        end
        mem_ready = 1'b1;
        #1;
        check("ld_memreq4", 32'(mem_req), 1);
        step();
        check("ld_wb", 32'(state), 5);
        check("ld_m2r", 32'(mem_to_reg), 1);
        check("ld_rw", 32'(reg_write), 1);
        check("ld_wb_memreq", 32'(mem_req), 0);
        step();
        check("ld_instret", instret, 2);
        opcode = OP_BR;
        zero = 1'b1;
        step();
        step();
        check("br1_exec", 32'(state), 3);
        check("br1_pwc", 32'(pc_write_cond), 1);
        check("br1_pw", 32'(pc_write), 0);
        check("br1_aluop", 32'(alu_op), 1);
        step();
        check("br1_fetch", 32'(state), 1);
        check("br1_instret", instret, 3);
        zero = 1'b0;
        step();
        step();
        check("br0_pwc", 32'(pc_write_cond), 0);
        step();
        check("br0_fetch", 32'(state), 1);
        check("br0_instret", instret, 4);
        opcode = OP_JAL;
        step();
        step();
        check("jal_pw", 32'(pc_write), 1);
        check("jal_alusrc", 32'(alu_src), 0);
        step();
        check("jal_wb", 32'(state), 5);
        step();
        check("jal_instret", instret, 5);
        opcode = OP_STORE;
        step();
        step();
        mem_ready = 1'b0;
        step();
        check("st_mem", 32'(state), 4);
        check("st_memwe", 32'(mem_we), 1);
        check("st_memreq", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("st_rst_memreq", 32'(mem_req), 0);
        check("st_rst_memwe", 32'(mem_we), 0);
        check("st_rst_state", 32'(state), 0);
        check("st_rst_instret", instret, 0);
        step();
        reset = 1'b0;
        step();
        check("fw_fetch", 32'(state), 1);
        check("fw_irwrite", 32'(ir_write), 0);
        step();
        check("fw_hold", 32'(state), 1);
        check("fw_memreq", 32'(mem_req), 1);
        #2 reset = 1'b1;
        #1;
        check("fw_rst_memreq", 32'(mem_req), 0);
        check("fw_rst_state", 32'(state), 0);
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'b0000000;
        step();
        step();
        step();
        check("trap_state", 32'(state), 7);
        check("trap_illegal", 32'(illegal), 1);
        check("trap_memreq", 32'(mem_req), 0);
        repeat (20) step();
        check("trap_hold", 32'(state), 7);
        check("trap_sticky", 32'(illegal), 1);
        check("trap_instret", instret, 0);
        reset = 1'b1;
        #1;
        check("trap_rst_ill", 32'(illegal), 0);
        check("trap_rst_state", 32'(state), 0);
        step();
        reset = 1'b0;
        opcode = OP_IMM;
        step();
        step();
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        step();
        check("imm_aluop", 32'(alu_op), 3);
        check("imm_alusrc", 32'(alu_src), 1);
        step();
        check("imm_wb", 32'(state), 5);
        step();
        check("wrap_instret", instret, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings below are fixed.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high. Ports are named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 zero  input  1  ALU zero flag; sampled in EXECUTE for branches.
REQ-008 mem_req, mem_we  output  1 each  memory access request and write enable.
REQ-009 ir_write, pc_write, pc_write_cond  output  1 each  IR load, unconditional PC load, and branch-qualified PC load.
REQ-010 reg_write, alu_src, mem_to_reg  output  1 each  register-file write, immediate ALU operand, and load-data writeback select.
REQ-011 alu_op  output  2  ALU operation class: 00 add, 01 subtract/compare, 10 R-type funct decode, 11 I-type funct decode.
REQ-012 state  output  3  current state: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=7.
REQ-013 illegal  output  1  sticky unrecognized-opcode flag.
REQ-014 instret  output  32  retired-instruction count.

Function
REQ-015 All outputs SHALL be Moore outputs, decoded from state plus the latched instruction class. The one exception is ir_write/pc_write in FETCH, which are additionally qualified by mem_ready.
REQ-016 IDLE: all strobes 0; next state is FETCH unconditionally.
REQ-017 FETCH: mem_req=1, mem_we=0. Hold FETCH while mem_ready=0. In the mem_ready=1 cycle, assert ir_write=1 and pc_write=1 (PC+4), alu_op=00, then go to DECODE.
REQ-018 DECODE: latch the class from opcode.
- Recognized opcodes and classes: R=0110011, LOAD=0000011, STORE=0100011, IMM=0010011, BR=1100011, JAL=1101111, JALR=1100111.
- Recognized opcode goes to EXECUTE; any other value goes to TRAP.
- All strobes are 0.
REQ-019 EXECUTE, by class:
- R: alu_src=0, alu_op=10; next WRITEBACK.
- IMM: alu_src=1, alu_op=11; next WRITEBACK.
- LOAD/STORE: alu_src=1, alu_op=00; next MEMORY.
- BR: alu_src=0, alu_op=01, pc_write_cond=zero; next FETCH.
- JAL/JALR: pc_write=1, alu_op=00, alu_src=1 for JALR and 0 for JAL; next WRITEBACK.
REQ-020 MEMORY: mem_req=1; mem_we=1 only for STORE. Hold while mem_ready=0. On mem_ready=1, LOAD goes to WRITEBACK and STORE goes to FETCH.
REQ-021 WRITEBACK: reg_write=1 for exactly one cycle; mem_to_reg=1 only for LOAD; next FETCH.
REQ-022 An instruction retires on every transition into FETCH from EXECUTE (BR), MEMORY (STORE) or WRITEBACK. instret increments by 1 on that edge and wraps 0xFFFFFFFF to 0.
REQ-023 TRAP: illegal=1, all other strobes 0; the FSM stays in TRAP until reset. instret does not increment on entry to TRAP.
REQ-024 mem_ready asserted outside FETCH/MEMORY SHALL be ignored. mem_req SHALL be held continuously until mem_ready is seen.
REQ-025 Strobes not listed for a state SHALL be 0 in that state. pc_write and pc_write_cond SHALL never both be 1.

Reset
REQ-026 reset=1 SHALL asynchronously force:
- state=IDLE;
- all strobes, alu_op and illegal to 0;
- instret=0;
- latched class cleared.
REQ-027 Reset asserted mid-operation (including while mem_req=1) SHALL drop mem_req in the same cycle. After reset deasserts, the next fetch begins one cycle later, via IDLE.

Verification
REQ-028 Reset release, opcode=0110011, mem_ready=1 in FETCH -> states 0,1,2,3,5,1; reg_write=1 only in state 5; instret=1.
REQ-029 LOAD with mem_ready held 0 for 3 cycles in MEMORY -> mem_req=1 for 4 cycles; then WRITEBACK with mem_to_reg=1, reg_write=1.
REQ-030 BR with zero=1, then BR with zero=0 -> pc_write_cond=1 then 0 in EXECUTE; no WRITEBACK visit; instret +2.
REQ-031 opcode=0000000 in DECODE -> state=7, illegal=1 stays set for 20 cycles; instret unchanged. Reset then clears illegal and returns state to 0.
REQ-032 Reset pulse during FETCH wait, and during MEMORY of a STORE -> mem_req and mem_we go 0 immediately; state=0; instret=0.
REQ-033 instret preloaded near 0xFFFFFFFF (force) plus one retire -> instret=0x00000000.
